multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables cycle by cycle.
- Waits on a memory ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the instruction register and the datapath; adds lw/sw, bne and j to the single-cycle opcode set.

Parameters:
ALU_OP_W, 3, alu_op_o width (>=3); codes are zero-extended into the upper bits.
CNT_W, 16, retired-instruction counter width.
MEM_TIMEOUT, 15, max cycles waiting on mem_ready_i in one access before trap (>=1).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
instr_op_i  in  6  opcode field of the instruction register
mem_ready_i  in  1  memory access complete this cycle
pc_write_o  out  1  PC update enable
ir_write_o  out  1  instruction register load
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
reg_write_o  out  1  register file write enable
alu_src_o  out  1  1 = immediate operand
reg_dst_o  out  1  1 = rd, 0 = rt
mem_to_reg_o  out  1  1 = writeback from memory
branch_o  out  1  beq/bne evaluate pulse
branch_ne_o  out  1  1 = bne polarity
jump_o  out  1  jump target select pulse
se_o  out  1  1 = sign-extend immediate
alu_op_o  out  ALU_OP_W  ALU control class
trap_o  out  1  sticky trap flag
state_o  out  3  current state encoding
retired_o  out  CNT_W  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset (rst_i low, async): state=FETCH, op register=0, timeout counter=0, retired_o=0, trap_o=0. All outputs held 0 while rst_i is low, including mem_read_o. Reset mid-instruction abandons it; no count increment.
- Outputs are Moore: decoded from state plus the latched opcode, not from instr_op_i except in DECODE.
- FETCH: mem_read_o=1. When mem_ready_i=1, pulse ir_write_o=1 and pc_write_o=1 in that same cycle, then go to DECODE. Otherwise stay.
- DECODE (always 1 cycle):
  - Latch instr_op_i into the op register.
  - Legal opcodes: 000000 R, 000100 beq, 000101 bne, 001000 addi, 001011 sltiu, 001111 lui, 001101 ori, 100011 lw, 101011 sw, 000010 j.
  - Legal opcode -> EXEC. Illegal opcode -> TRAP, trap_o=1.
- EXEC (1 cycle), using the latched op:
  - alu_op_o: R=000, beq/bne=001, addi/lw/sw=010, lui=011, ori=100, sltiu=101.
  - alu_src_o=1 for all I-type, lw and sw.
  - se_o=1 for addi, lw, sw, beq, bne; se_o=0 otherwise.
  - beq/bne: branch_o=1; branch_ne_o=1 for bne only. Then FETCH, retire.
  - j: jump_o=1 and pc_write_o=1. Then FETCH, retire.
  - lw/sw -> MEM. R and other I-type -> WB.
- MEM:
  - lw: mem_read_o=1. sw: mem_write_o=1.
  - Hold the request until mem_ready_i. Then lw -> WB; sw -> FETCH, retire.
- WB (1 cycle): reg_write_o=1.
  - R: reg_dst_o=1.
  - lw: mem_to_reg_o=1, reg_dst_o=0.
  - I-type: reg_dst_o=0.
  - Then FETCH, retire.
- Retire: retired_o increments by 1 on the transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each cycle in FETCH/MEM while mem_ready_i=0.
  - If the count reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP.
  - mem_ready_i=1 in the same cycle the limit is reached wins: normal completion.
- mem_ready_i is ignored outside FETCH/MEM.
- TRAP: all enables 0, trap_o=1, retired_o frozen. Exit only via reset.
- Cycle counts with zero-wait memory: R/I = 4, beq/bne/j = 3, lw = 5, sw = 4.

Test Plan:
- Reset, then R-type (000000) with mem_ready_i=1 constantly -> state_o 0,1,2,4,0; reg_write_o=1 and reg_dst_o=1 in WB; retired_o=1 after 4 cycles.
- lw (100011) with fetch ready after 2 wait cycles and MEM ready after 1 -> mem_read_o high 3 cycles in FETCH; mem_to_reg_o=1 in WB; total 8 cycles; retired_o+1.
- bne (000101) then j (000010) -> EXEC shows branch_o=1, branch_ne_o=1, se_o=1, alu_op_o=001; then jump_o=1, pc_write_o=1; retired_o+2 after 6 cycles.
- Opcode 111111 -> TRAP in the cycle after DECODE; trap_o=1; all enables 0 for 20 cycles; retired_o unchanged; rst_i low clears it asynchronously.
- mem_ready_i held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP on cycle 16. Repeat with ready asserted on cycle 15 -> DECODE, no trap.
- Assert rst_i low mid-MEM for a sw -> mem_write_o drops immediately, state_o=0, retired_o=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, trap and retire count.
// Moore outputs (FETCH ir/pc pulses follow mem_ready_i); stalls in FETCH/MEM on mem_ready_i, traps after MEM_TIMEOUT waits.
module multicycle_ctrl #(
    parameter int ALU_OP_W    = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                alu_src_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                branch_o,
    output logic                branch_ne_o,
    output logic                jump_o,
    output logic                se_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                trap_o,
    output logic [2:0]          state_o,
    output logic [CNT_W-1:0]    retired_o
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [CNT_W-1:0]   retired_q;
    logic               trap_q;
    logic               legal;
    logic               mem_wait;
    logic               tmo_hit;
    logic               retire;
    logic [2:0]         alu_cls;

    always_comb begin
        case (instr_op_i)
            OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU,
            OP_LUI, OP_ORI, OP_LW, OP_SW, OP_J: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

    // A ready in the same cycle the limit is reached still completes the access.
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i;
    assign tmo_hit  = mem_wait && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i)  state_d = S_DECODE;
                else if (tmo_hit) state_d = S_TRAP;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (op_q)
                    OP_BEQ, OP_BNE, OP_J: state_d = S_FETCH;
                    OP_LW, OP_SW:         state_d = S_MEM;
                    default:              state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i)  state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (tmo_hit) state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= instr_op_i;
            if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
                tmo_q <= '0;
            else if (mem_wait)
                tmo_q <= tmo_q + 1'b1;
            if (retire) retired_q <= retired_q + 1'b1;
            if (state_d == S_TRAP) trap_q <= 1'b1;
        end
    end

    // Enables are forced low while reset is held, even though the reset state is FETCH.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        branch_o     = 1'b0;
        branch_ne_o  = 1'b0;
        jump_o       = 1'b0;
        se_o         = 1'b0;
        alu_cls      = 3'd0;
        if (rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o = 1'b1;
                    ir_write_o = mem_ready_i;
                    pc_write_o = mem_ready_i;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_BEQ: begin
                            branch_o = 1'b1;
                            se_o     = 1'b1;
                            alu_cls  = 3'd1;
                        end
                        OP_BNE: begin
                            branch_o    = 1'b1;
                            branch_ne_o = 1'b1;
                            se_o        = 1'b1;
                            alu_cls     = 3'd1;
                        end
                        OP_ADDI, OP_LW, OP_SW: begin
                            alu_src_o = 1'b1;
                            se_o      = 1'b1;
                            alu_cls   = 3'd2;
                        end
                        OP_LUI: begin
                            alu_src_o = 1'b1;
                            alu_cls   = 3'd3;
                        end
                        OP_ORI: begin
                            alu_src_o = 1'b1;
                            alu_cls   = 3'd4;
                        end
                        OP_SLTIU: begin
                            alu_src_o = 1'b1;
                            alu_cls   = 3'd5;
                        end
                        OP_J: begin
                            jump_o     = 1'b1;
                            pc_write_o = 1'b1;
                        end
                        default: alu_cls = 3'd0;
                    endcase
                end
                S_MEM: begin
                    mem_read_o  = (op_q == OP_LW);
                    mem_write_o = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (op_q == OP_R);
                    mem_to_reg_o = (op_q == OP_LW);
                end
                default: begin
                    pc_write_o = 1'b0;
                end
            endcase
        end
    end

    assign alu_op_o  = ALU_OP_W'(alu_cls);
    assign trap_o    = trap_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, per-instruction transaction model with random waits, corner sequences.
module tb_multicycle_ctrl;

    localparam int ALU_OP_W    = 3;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic [5:0]          instr_op_i = '0;
    logic                mem_ready_i = 1'b0;
    logic                pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o;
    logic                alu_src_o, reg_dst_o, mem_to_reg_o, branch_o, branch_ne_o, jump_o, se_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic                trap_o;
    logic [2:0]          state_o;
    logic [CNT_W-1:0]    retired_o;
    logic [11:0]         act_en;

    multicycle_ctrl #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .alu_src_o(alu_src_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o),
        .branch_ne_o(branch_ne_o), .jump_o(jump_o), .se_o(se_o), .alu_op_o(alu_op_o),
        .trap_o(trap_o), .state_o(state_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    assign act_en = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o, alu_src_o,
                     reg_dst_o, mem_to_reg_o, branch_o, branch_ne_o, jump_o, se_o};

    localparam logic [11:0] E_PC = 12'h800, E_IR = 12'h400, E_MR = 12'h200, E_MW = 12'h100;
    localparam logic [11:0] E_RW = 12'h080, E_AS = 12'h040, E_RD = 12'h020, E_M2R = 12'h010;
    localparam logic [11:0] E_BR = 12'h008, E_BNE = 12'h004, E_J = 12'h002, E_SE = 12'h001;
    localparam logic [11:0] E_FD = E_PC | E_IR | E_MR;
    localparam logic [5:0]  XOP = 6'h3F;

    typedef struct {
        logic       rdy;
        logic [5:0] op;
        logic [2:0] st;
        logic [11:0] en;
        logic [2:0] alu;
        int         ret;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ret = 0;
    vec_t tbl[$];
    logic [5:0] legal_ops[10] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0B, 6'h0F, 6'h0D, 6'h23, 6'h2B, 6'h02};

    function automatic vec_t mkv(logic rdy, logic [5:0] op, logic [2:0] st, logic [11:0] en,
                                 logic [2:0] alu, int ret);
        vec_t v;
        v.rdy = rdy; v.op = op; v.st = st; v.en = en; v.alu = alu; v.ret = ret;
        return v;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        return op inside {6'h00, 6'h04, 6'h05, 6'h08, 6'h0B, 6'h0F, 6'h0D, 6'h23, 6'h2B, 6'h02};
    endfunction

    function automatic logic [11:0] exec_en(logic [5:0] op);
        case (op)
            6'h04:               return E_BR | E_SE;
            6'h05:               return E_BR | E_BNE | E_SE;
            6'h08, 6'h23, 6'h2B: return E_AS | E_SE;
            6'h0B, 6'h0F, 6'h0D: return E_AS;
            6'h02:               return E_J | E_PC;
            default:             return 12'h000;
        endcase
    endfunction

    function automatic logic [2:0] exec_alu(logic [5:0] op);
        case (op)
            6'h04, 6'h05:        return 3'd1;
            6'h08, 6'h23, 6'h2B: return 3'd2;
            6'h0F:               return 3'd3;
            6'h0D:               return 3'd4;
            6'h0B:               return 3'd5;
            default:             return 3'd0;
        endcase
    endfunction

    task automatic check(string name, logic [2:0] st, logic [11:0] en, logic [2:0] alu,
                         logic trap, int ret);
        n_cmp++;
        if (state_o !== st || act_en !== en || alu_op_o !== alu || trap_o !== trap ||
            retired_o !== CNT_W'(ret)) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d en=%03h alu=%0d trap=%b ret=%0d, need st=%0d en=%03h alu=%0d trap=%b ret=%0d",
                     name, $time, state_o, act_en, alu_op_o, trap_o, retired_o,
                     st, en, alu, trap, ret % (1 << CNT_W));
        end
    endtask

    // Called at a falling edge; applies inputs, samples, and advances to the next falling edge.
    task automatic step(string name, logic rdy, logic [5:0] op, logic [2:0] st, logic [11:0] en,
                        logic [2:0] alu, logic trap, int ret);
        mem_ready_i = rdy;
        instr_op_i  = op;
        #1;
        check(name, st, en, alu, trap, ret);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        #2;
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check("reset", 3'd0, 12'h000, 3'd0, 1'b0, 0);
        m_ret = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i       = 1'b1;
        mem_ready_i = 1'b0;
    endtask

    task automatic retire();
        m_ret = (m_ret + 1) % (1 << CNT_W);
    endtask

    // Expected cycle-by-cycle trace of one legal instruction given its wait counts.
    task automatic run_instr(logic [5:0] op, int fw, int mw);
        logic [11:0] men;
        men = (op == 6'h23) ? E_MR : E_MW;
        for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, rnd6(), 3'd0, E_MR, 3'd0, 1'b0, m_ret);
        step("fetch_done", 1'b1, rnd6(), 3'd0, E_FD, 3'd0, 1'b0, m_ret);
        step("decode", rbit(), op, 3'd1, 12'h000, 3'd0, 1'b0, m_ret);
        step("exec", rbit(), rnd6(), 3'd2, exec_en(op), exec_alu(op), 1'b0, m_ret);
        if (op inside {6'h04, 6'h05, 6'h02}) begin
            retire();
        end else begin
            if (op inside {6'h23, 6'h2B}) begin
                for (int i = 0; i < mw; i++) step("mem_wait", 1'b0, rnd6(), 3'd3, men, 3'd0, 1'b0, m_ret);
                step("mem_done", 1'b1, rnd6(), 3'd3, men, 3'd0, 1'b0, m_ret);
            end
            if (op != 6'h2B)
                step("wb", rbit(), rnd6(), 3'd4,
                     E_RW | ((op == 6'h00) ? E_RD : 12'h000) | ((op == 6'h23) ? E_M2R : 12'h000),
                     3'd0, 1'b0, m_ret);
            retire();
        end
    endtask

    initial begin
        logic [5:0] op;
        int fw, mw;

        // R, lw (2 fetch waits, 1 mem wait), bne, j, sw, ori
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 0));
        tbl.push_back(mkv(1, 6'h00, 1, 12'h000,      0, 0));
        tbl.push_back(mkv(1, XOP,   2, 12'h000,      0, 0));
        tbl.push_back(mkv(1, XOP,   4, E_RW | E_RD,  0, 0));
        tbl.push_back(mkv(0, XOP,   0, E_MR,         0, 1));
        tbl.push_back(mkv(0, XOP,   0, E_MR,         0, 1));
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 1));
        tbl.push_back(mkv(0, 6'h23, 1, 12'h000,      0, 1));
        tbl.push_back(mkv(0, XOP,   2, E_AS | E_SE,  2, 1));
        tbl.push_back(mkv(0, XOP,   3, E_MR,         0, 1));
        tbl.push_back(mkv(1, XOP,   3, E_MR,         0, 1));
        tbl.push_back(mkv(0, XOP,   4, E_RW | E_M2R, 0, 1));
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 2));
        tbl.push_back(mkv(1, 6'h05, 1, 12'h000,      0, 2));
        tbl.push_back(mkv(1, XOP,   2, E_BR | E_BNE | E_SE, 1, 2));
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 3));
        tbl.push_back(mkv(1, 6'h02, 1, 12'h000,      0, 3));
        tbl.push_back(mkv(1, XOP,   2, E_J | E_PC,   0, 3));
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 4));
        tbl.push_back(mkv(1, 6'h2B, 1, 12'h000,      0, 4));
        tbl.push_back(mkv(1, XOP,   2, E_AS | E_SE,  2, 4));
        tbl.push_back(mkv(1, XOP,   3, E_MW,         0, 4));
        tbl.push_back(mkv(1, XOP,   0, E_FD,         0, 5));
        tbl.push_back(mkv(1, 6'h0D, 1, 12'h000,      0, 5));
        tbl.push_back(mkv(1, XOP,   2, E_AS,         4, 5));
        tbl.push_back(mkv(1, XOP,   4, E_RW,         0, 5));
        tbl.push_back(mkv(0, XOP,   0, E_MR,         0, 6));

        @(negedge clk_i);
        do_reset();
        foreach (tbl[i]) step("table", tbl[i].rdy, tbl[i].op, tbl[i].st, tbl[i].en, tbl[i].alu, 1'b0, tbl[i].ret);
        m_ret = 6;
        step("table_tail", 1'b0, XOP, 3'd0, E_MR, 3'd0, 1'b0, m_ret);

        // Random legal instruction stream with random wait counts; counter wraps at 2^CNT_W.
        for (int n = 0; n < 150; n++) begin
            op = legal_ops[$urandom_range(0, 9)];
            fw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
            run_instr(op, fw, mw);
        end
        step("rand_end", 1'b0, rnd6(), 3'd0, E_MR, 3'd0, 1'b0, m_ret);

        // Illegal opcode: sticky trap, no enables, count frozen, then async clear
        step("ill_fetch", 1'b1, XOP, 3'd0, E_FD, 3'd0, 1'b0, m_ret);
        step("ill_decode", 1'b1, 6'h3F, 3'd1, 12'h000, 3'd0, 1'b0, m_ret);
        for (int i = 0; i < 20; i++) step("trap_hold", rbit(), rnd6(), 3'd7, 12'h000, 3'd0, 1'b1, m_ret);
        do_reset();
        do op = rnd6(); while (is_legal(op));
        step("ill2_fetch", 1'b1, XOP, 3'd0, E_FD, 3'd0, 1'b0, 0);
        step("ill2_decode", 1'b0, op, 3'd1, 12'h000, 3'd0, 1'b0, 0);
        step("ill2_trap", 1'b1, 6'h00, 3'd7, 12'h000, 3'd0, 1'b1, 0);
        do_reset();

        // Fetch timeout: 15 unready cycles trap; ready on the 15th completes
        for (int i = 0; i < MEM_TIMEOUT; i++) step("fetch_to", 1'b0, XOP, 3'd0, E_MR, 3'd0, 1'b0, 0);
        step("fetch_to_trap", 1'b0, XOP, 3'd7, 12'h000, 3'd0, 1'b1, 0);
        do_reset();
        run_instr(6'h00, MEM_TIMEOUT - 1, 0);
        step("fetch_limit_ok", 1'b1, XOP, 3'd0, E_FD, 3'd0, 1'b0, m_ret);
        step("fetch_limit_dec", 1'b0, 6'h23, 3'd1, 12'h000, 3'd0, 1'b0, m_ret);
        step("fetch_limit_exec", 1'b0, XOP, 3'd2, E_AS | E_SE, 3'd2, 1'b0, m_ret);

        // Memory timeout: counter restarts in MEM, then a full wait traps
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("mem_lim", 1'b0, XOP, 3'd3, E_MR, 3'd0, 1'b0, m_ret);
        step("mem_lim_done", 1'b1, XOP, 3'd3, E_MR, 3'd0, 1'b0, m_ret);
        step("mem_lim_wb", 1'b0, XOP, 3'd4, E_RW | E_M2R, 3'd0, 1'b0, m_ret);
        retire();
        step("mem_to_fetch", 1'b1, XOP, 3'd0, E_FD, 3'd0, 1'b0, m_ret);
        step("mem_to_dec", 1'b0, 6'h2B, 3'd1, 12'h000, 3'd0, 1'b0, m_ret);
        step("mem_to_exec", 1'b0, XOP, 3'd2, E_AS | E_SE, 3'd2, 1'b0, m_ret);
        for (int i = 0; i < MEM_TIMEOUT; i++) step("mem_to", 1'b0, XOP, 3'd3, E_MW, 3'd0, 1'b0, m_ret);
        step("mem_to_trap", 1'b1, XOP, 3'd7, 12'h000, 3'd0, 1'b1, m_ret);
        do_reset();

        // Reset in the middle of a store's memory wait
        run_instr(6'h08, 0, 0);
        run_instr(6'h00, 1, 0);
        step("sw_fetch", 1'b1, XOP, 3'd0, E_FD, 3'd0, 1'b0, m_ret);
        step("sw_dec", 1'b1, 6'h2B, 3'd1, 12'h000, 3'd0, 1'b0, m_ret);
        step("sw_exec", 1'b1, XOP, 3'd2, E_AS | E_SE, 3'd2, 1'b0, m_ret);
        step("sw_mem", 1'b0, XOP, 3'd3, E_MW, 3'd0, 1'b0, m_ret);
        step("sw_mem2", 1'b0, XOP, 3'd3, E_MW, 3'd0, 1'b0, m_ret);
        do_reset();
        step("post_reset", 1'b0, XOP, 3'd0, E_MR, 3'd0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
